// File: rtl/display_pkg.sv
// Shared types and constants for the hex display arbiter and its decoder.
// Latency: none (declarations only).
// Backpressure: n/a.
package display_pkg;

  // Number of multiplexed 7-segment digits and the width of the digit index
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  // Lookup table indexed by nibble value (entry 0 is the rightmost slice)
  localparam logic [15:0][6:0] SEG_HEX = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // One-hot-low anode enable for the given digit index
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/hex_display_arbiter.sv
// Two-requester round-robin owner of a 4-digit multiplexed hex display.
// Latency: ack one cycle after request is sampled; an/seg one cycle behind idx/disp_reg.
// Backpressure: requests seen during HOLD stay pending until the next IDLE cycle.
module hex_display_arbiter
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] val_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  input  logic        blank,
  output logic        ack_a,
  output logic        ack_b,
  output logic        owner,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(HOLD_CYCLES - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [15:0]      disp_reg;
  logic             last_b;       // 1 when B was the last requester served
  logic [RW-1:0]    refresh_cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic             grant_b;

  // B wins when it is alone, or on a tie when A was served last
  assign grant_b    = req_b & (~req_a | ~last_b);
  assign cur_nibble = disp_reg[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Arbitration FSM: grant in IDLE, then own the display for HOLD_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      disp_reg <= 16'h0000;
      last_b   <= 1'b1;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      owner    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_a | req_b) begin
            disp_reg <= grant_b ? val_b : val_a;
            owner    <= grant_b;
            last_b   <= grant_b;
            ack_a    <= ~grant_b;
            ack_b    <= grant_b;
            hold_cnt <= HOLD_LOAD;
            busy     <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running refresh divider; each wrap steps to the next digit
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      idx         <= idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Registered display drive, forced dark while blank is asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= digit_enable(idx);
      seg <= cur_seg;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter (REFRESH_DIV=4, HOLD_CYCLES=8) plus a HOLD_CYCLES=1 instance.
// Latency: cycle numbers count edges after the last reset edge (cycle 0 = first cycle out of reset).
// Backpressure: n/a.
module tb_hex_display_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [15:0] val_a = 16'h0000;
  logic [15:0] val_b = 16'h0000;
  logic        blank = 1'b0;

  logic        ack_a, ack_b, owner, busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ack_a1, ack_b1, owner1, busy1;
  logic [3:0]  an1;
  logic [6:0]  seg1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  hex_display_arbiter #(.REFRESH_DIV(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .blank(blank), .ack_a(ack_a), .ack_b(ack_b), .owner(owner), .busy(busy), .an(an), .seg(seg)
  );

  hex_display_arbiter #(.REFRESH_DIV(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
    .blank(blank), .ack_a(ack_a1), .ack_b(ack_b1), .owner(owner1), .busy(busy1), .an(an1), .seg(seg1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    cyc = 0;
    rst = 1'b0;
  endtask

  logic [3:0] exp_an [4];

  initial begin
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset state and idle scan of 0000
    do_reset();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_ack_a", ack_a, 1'b0);
    check("rst_ack_b", ack_b, 1'b0);
    check("rst_owner", owner, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int d = 0; d < 4; d++) begin
      run_to(1 + 4 * d);
      check("idle_an", an, exp_an[d]);
      check("idle_seg", seg, 7'b1000000);
    end
    run_to(17);
    check("idle_an_wrap", an, 4'b1110);

    // Single grant to A, value 1A2F
    do_reset();
    req_a = 1'b1;
    val_a = 16'h1A2F;
    run_to(1);
    check("a_ack", ack_a, 1'b1);
    check("a_ack_b", ack_b, 1'b0);
    check("a_owner", owner, 1'b0);
    check("a_busy", busy, 1'b1);
    check("a_seg_old", seg, 7'b1000000);
    req_a = 1'b0;
    run_to(2);
    check("a_ack_drop", ack_a, 1'b0);
    check("a_seg_d0", seg, 7'b0001110);
    run_to(5);
    check("a_an_d1", an, 4'b1101);
    check("a_seg_d1", seg, 7'b0100100);
    run_to(8);
    check("a_busy_last", busy, 1'b1);
    run_to(9);
    check("a_busy_end", busy, 1'b0);
    check("a_seg_d2", seg, 7'b0001000);
    run_to(13);
    check("a_seg_d3", seg, 7'b1111001);
    run_to(17);
    check("a_seg_d0b", seg, 7'b0001110);

    // Both requesting from reset: A, then B 9 cycles later, then A again
    req_a = 1'b1;
    req_b = 1'b1;
    val_a = 16'h1A2F;
    val_b = 16'hBEEF;
    do_reset();
    run_to(1);
    check("tie_ack_a", ack_a, 1'b1);
    check("tie_ack_b", ack_b, 1'b0);
    check("tie_owner", owner, 1'b0);
    check("h1_ack_a", ack_a1, 1'b1);
    run_to(3);
    check("h1_ack_b", ack_b1, 1'b1);
    check("h1_owner", owner1, 1'b1);
    run_to(9);
    check("tie_b_early", ack_b, 1'b0);
    check("tie_idle_busy", busy, 1'b0);
    run_to(10);
    check("tie_b_ack", ack_b, 1'b1);
    check("tie_b_ack_a", ack_a, 1'b0);
    check("tie_b_owner", owner, 1'b1);
    check("tie_b_busy", busy, 1'b1);
    run_to(11);
    check("beef_an_d2", an, 4'b1011);
    check("beef_seg_d2", seg, 7'b0000110);
    run_to(13);
    check("beef_seg_d3", seg, 7'b0000011);
    run_to(17);
    check("beef_seg_d0", seg, 7'b0001110);
    run_to(19);
    check("rr_ack_a", ack_a, 1'b1);
    check("rr_owner", owner, 1'b0);
    req_a = 1'b0;
    req_b = 1'b0;

    // B arrives during A's HOLD and changes its value before being served
    do_reset();
    req_a = 1'b1;
    val_a = 16'h1234;
    run_to(1);
    check("p_ack_a", ack_a, 1'b1);
    req_a = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      run_to(c);
      check("p_no_ack_b", ack_b, 1'b0);
      if (c == 3) begin
        req_b = 1'b1;
        val_b = 16'h5678;
      end
      if (c == 5) val_b = 16'h9ABC;
      if (c == 6) check("p_seg_hold", seg, 7'b0110000);
    end
    run_to(10);
    check("p_ack_b", ack_b, 1'b1);
    check("p_owner", owner, 1'b1);
    req_b = 1'b0;
    run_to(11);
    check("p_seg_d2", seg, 7'b0001000);
    run_to(13);
    check("p_seg_d3", seg, 7'b0010000);

    // Blank for 10 sampled cycles in mid-scan
    do_reset();
    req_a = 1'b1;
    val_a = 16'h1A2F;
    run_to(1);
    req_a = 1'b0;
    run_to(6);
    blank = 1'b1;
    for (int c = 7; c <= 16; c++) begin
      run_to(c);
      check("blank_an", an, 4'b1111);
      check("blank_seg", seg, 7'b1111111);
    end
    blank = 1'b0;
    run_to(17);
    check("unblank_an", an, 4'b1110);
    check("unblank_seg", seg, 7'b0001110);

    // Reset on the 3rd HOLD cycle with B pending through reset
    do_reset();
    req_a = 1'b1;
    val_a = 16'h1A2F;
    run_to(1);
    check("r_ack_a", ack_a, 1'b1);
    req_a = 1'b0;
    req_b = 1'b1;
    val_b = 16'hBEEF;
    run_to(3);
    check("r_busy_pre", busy, 1'b1);
    rst = 1'b1;
    run_to(4);
    check("r_busy", busy, 1'b0);
    check("r_ack_a_none", ack_a, 1'b0);
    check("r_ack_b_none", ack_b, 1'b0);
    check("r_owner", owner, 1'b0);
    check("r_an", an, 4'b1111);
    check("r_seg", seg, 7'b1111111);
    rst = 1'b0;
    run_to(5);
    check("r_ack_b", ack_b, 1'b1);
    check("r_owner_b", owner, 1'b1);
    check("r_an_d0", an, 4'b1110);
    check("r_disp_clr", seg, 7'b1000000);
    req_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter REFRESH_DIV, default 1000: clock cycles each digit stays lit; legal range is 2 or more.
REQ-003 Parameter HOLD_CYCLES, default 16: minimum cycles a granted value owns the display; legal range is 1 or more.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_a  in  1  requester A (CPU result path) asks for the display.
REQ-007 val_a  in  16  requester A value, 4 hex nibbles; stable while req_a is high.
REQ-008 req_b  in  1  requester B (debug/monitor path) asks for the display.
REQ-009 val_b  in  16  requester B value, 4 hex nibbles.
REQ-010 blank  in  1  forces all digits dark.
REQ-011 ack_a, ack_b  out  1 each  one-cycle grant pulse to the requester whose value was latched.
REQ-012 owner  out  1  owner of the current display value: 0 = A, 1 = B.
REQ-013 busy  out  1  high while in HOLD.
REQ-014 an  out  4  digit enables, active-low, one-hot-low; bit 0 = least significant nibble.
REQ-015 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-016 The FSM SHALL have two states, IDLE and HOLD.
- IDLE with no request: stay in IDLE.
- IDLE with any request sampled high: latch the granted value into disp_reg, load hold_cnt = HOLD_CYCLES-1, go to HOLD.
REQ-017 The matching ack SHALL be high for exactly the one cycle after the sampling edge, together with the updated owner; latency from req sampled to ack visible is 1 cycle.
REQ-018 In HOLD, hold_cnt SHALL decrement each cycle.
- Return to IDLE on the edge where hold_cnt equals 0.
- HOLD_CYCLES=1 gives exactly one HOLD cycle.
REQ-019 Requests during HOLD SHALL be neither acked nor latched; they stay pending and are arbitrated in the first IDLE cycle.
REQ-020 If only one request is high in IDLE, that requester SHALL be granted.
REQ-021 If both are high, the requester that is not the last-served one (round-robin) SHALL be granted.
REQ-022 A requester still holding req after its ack SHALL be treated as a new request at the next IDLE, subject to REQ-021.
REQ-023 The refresh counter SHALL run free from 0 to REFRESH_DIV-1 and wrap.
- On each wrap, digit index idx advances 0, 1, 2, 3, 0.
- The counter and idx run regardless of FSM state or blank.
REQ-024 an and seg SHALL be registered, one cycle behind idx and disp_reg.
- an = ~(1<<idx).
- seg = active-low decode of disp_reg[4*idx+3:4*idx].
REQ-025 Decode SHALL cover 0-F; 0 decodes to 7'b1000000, F to 7'b0001110.
REQ-026 When blank is sampled high, an SHALL be 4'b1111 and seg 7'b1111111 on the next cycle; arbitration and latching continue.

Reset
REQ-027 On rst high at an edge, the block SHALL set:
- state IDLE, hold_cnt 0, disp_reg 16'h0000;
- ack_a/ack_b 0, owner 0, busy 0;
- refresh counter 0, idx 0;
- an 4'b1111, seg 7'b1111111;
- last-served = B, so A wins the first tie.
REQ-028 Reset during HOLD SHALL abort the hold without ack, and pending requests SHALL be re-arbitrated from IDLE after reset is released.

Structure
REQ-029 The FSM state encodings, the segment constants for blank and for each hex digit, and the digit count (4) SHALL live in the shared package display_pkg.
REQ-030 The decode SHALL be the combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out), instanced once on the idx-selected nibble.

Verification (REFRESH_DIV=4, HOLD_CYCLES=8)
REQ-031 Reset release, no requests -> outputs as in REQ-027 for one cycle, then an cycles 1110, 1101, 1011, 0111 every 4 cycles with seg=7'b1000000.
REQ-032 req_a with val_a=16'h1A2F in IDLE:
- ack_a pulses one cycle later, owner=0, busy high for 8 cycles;
- scan shows F, 2, A, 1 on an bits 0-3.
REQ-033 req_a and req_b both high from reset, val_b=16'hBEEF:
- A is acked first;
- B is acked exactly 9 cycles later (8 HOLD cycles plus 1 IDLE cycle), owner=1, display shows BEEF.
REQ-034 req_b pulsed during A's HOLD and held -> no ack_b until the cycle after HOLD ends; val_b changes during HOLD are not displayed.
REQ-035 blank high for 10 cycles mid-scan -> an=1111 and seg=1111111 throughout; idx continues, and the correct digit for the current idx reappears the cycle after blank falls.
REQ-036 rst asserted on the 3rd HOLD cycle -> state IDLE, disp_reg 0, no ack; a req_b held through reset is acked the cycle after rst falls.
